// File: rtl/waveform_pkg.sv
// Shared types and defaults for the waveform sandbox run controller.
//   sched_state_t : run controller states
//   DEF_*         : default divide ratios and run length
//   div_cnt_width : counter width needed to count 0..div-1 (at least 1 bit)
package waveform_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sched_state_t;

   localparam int unsigned DEF_FAST_DIV   = 1;
   localparam int unsigned DEF_MED_DIV    = 100;
   localparam int unsigned DEF_SLOW_DIV   = 1000;
   localparam int unsigned DEF_RUN_CYCLES = 20000;
   localparam int unsigned DEF_CW         = 32;

   function automatic int unsigned div_cnt_width(input int unsigned div);
      if (div <= 1) return 1;
      return $clog2(div);
   endfunction

endpackage

// File: rtl/tick_divider.sv
// Programmable tick divider: one-cycle strobe each time the counter wraps
// and a square wave that toggles with every strobe.
//   clk, rst : clock, async active-high reset
//   clr      : clear counter and wave (takes priority over run)
//   run      : advance the counter on this edge
//   strobe   : registered one-cycle tick every DIV run edges
//   wave     : registered toggle on each strobe
module tick_divider
   import waveform_pkg::*;
#(
   parameter int unsigned DIV = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic run,
   output logic strobe,
   output logic wave
);

   localparam int unsigned CNT_W = div_cnt_width(DIV);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             strobe_q, strobe_d;
   logic             wave_q, wave_d;
   logic             wrap;

   // Next-state: strobe only ever rises on a wrapping run edge, so it drops
   // automatically one cycle later (or stays high every cycle when DIV=1).
   always_comb begin
      wrap     = (cnt_q == CNT_W'(DIV - 1));
      cnt_d    = cnt_q;
      strobe_d = 1'b0;
      wave_d   = wave_q;
      if (clr) begin
         cnt_d  = '0;
         wave_d = 1'b0;
      end else if (run) begin
         if (wrap) begin
            cnt_d    = '0;
            strobe_d = 1'b1;
            wave_d   = ~wave_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q    <= '0;
         strobe_q <= 1'b0;
         wave_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         strobe_q <= strobe_d;
         wave_q   <= wave_d;
      end
   end

   assign strobe = strobe_q;
   assign wave   = wave_q;

endmodule

// File: rtl/clk_sched_ctrl.sv
// Run controller and tick scheduler: one clock, three registered enable
// strobes with matching square waves, and a bounded run length.
//   clk, rst              : clock, async active-high reset
//   start, stop           : level-sampled run control (stop wins)
//   fast/med/slow_en      : one-cycle strobes every *_DIV run cycles
//   fast/med/slow_wave    : toggle on each matching strobe
//   busy, done            : RUN / DONE state flags
//   cycle_cnt             : run cycles elapsed
module clk_sched_ctrl
   import waveform_pkg::*;
#(
   parameter int unsigned FAST_DIV   = DEF_FAST_DIV,
   parameter int unsigned MED_DIV    = DEF_MED_DIV,
   parameter int unsigned SLOW_DIV   = DEF_SLOW_DIV,
   parameter int unsigned RUN_CYCLES = DEF_RUN_CYCLES,
   parameter int unsigned CW         = DEF_CW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          stop,
   output logic          fast_en,
   output logic          med_en,
   output logic          slow_en,
   output logic          fast_wave,
   output logic          med_wave,
   output logic          slow_wave,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] cycle_cnt
);

   sched_state_t  state_q, state_d;
   logic [CW-1:0] cycle_cnt_q, cycle_cnt_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          last_cycle;
   logic          div_clr;
   logic          div_run;

   // Next state, cycle counter and divider controls.
   always_comb begin
      state_d     = state_q;
      cycle_cnt_d = cycle_cnt_q;
      last_cycle  = (cycle_cnt_q == CW'(RUN_CYCLES - 1));

      case (state_q)
         IDLE: begin
            if (start && !stop) begin
               state_d     = RUN;
               cycle_cnt_d = '0;
            end
         end
         RUN: begin
            // The abort edge is still a run cycle, so it is counted.
            cycle_cnt_d = cycle_cnt_q + CW'(1);
            if (stop)            state_d = IDLE;
            else if (last_cycle) state_d = DONE;
         end
         DONE: begin
            if (stop) begin
               state_d = IDLE;
            end else if (start) begin
               state_d     = RUN;
               cycle_cnt_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase

      // Dividers advance only on edges that stay in RUN, which suppresses a
      // strobe on the final or abort edge. Waves clear on RUN entry and in IDLE.
      div_run = (state_q == RUN) && (state_d == RUN);
      div_clr = (state_d == IDLE) || ((state_d == RUN) && (state_q != RUN));

      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cycle_cnt_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cycle_cnt_q <= cycle_cnt_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   tick_divider #(.DIV(FAST_DIV)) u_fast (
      .clk    (clk),
      .rst    (rst),
      .clr    (div_clr),
      .run    (div_run),
      .strobe (fast_en),
      .wave   (fast_wave)
   );

   tick_divider #(.DIV(MED_DIV)) u_med (
      .clk    (clk),
      .rst    (rst),
      .clr    (div_clr),
      .run    (div_run),
      .strobe (med_en),
      .wave   (med_wave)
   );

   tick_divider #(.DIV(SLOW_DIV)) u_slow (
      .clk    (clk),
      .rst    (rst),
      .clr    (div_clr),
      .run    (div_run),
      .strobe (slow_en),
      .wave   (slow_wave)
   );

   assign busy      = busy_q;
   assign done      = done_q;
   assign cycle_cnt = cycle_cnt_q;

endmodule
